// File: rtl/ws2812_driver.sv
// ws2812_driver
// Serialises 24-bit GRB pixels onto a single-wire WS2812 LED chain.
// Each bit occupies TBIT clocks. The line is high for T1H clocks for a '1'
// and T0H clocks for a '0', then low for the rest of the bit period.
// A pixel flagged as last is followed by a RESET_CYCLES low latch period.
//
// Ports
//   clk        system clock (50 MHz domain)
//   reset_n    asynchronous active-low reset
//   pix_data   pixel, GRB order, bit 23 transmitted first
//   pix_last   marks pix_data as the final pixel of a frame
//   pix_valid  upstream offers a pixel
//   pix_ready  driver takes the pixel on this cycle's rising edge
//   led_dout   registered serial output to the LED chain
//   busy       high whenever the driver is not idle
//
// state | meaning
// IDLE  | line low, waiting for a pixel
// SEND  | shifting out the 24 bits of the current pixel
// LATCH | line held low so the chain latches its data (also entered on reset)

module ws2812_driver #(
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int TBIT         = 62,
    parameter int RESET_CYCLES = 15000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        led_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [15:0] T0H_W  = 16'(T0H);
    localparam logic [15:0] T1H_W  = 16'(T1H);
    localparam logic [15:0] TBIT_M = 16'(TBIT - 1);
    localparam logic [15:0] RST_M  = 16'(RESET_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  idx, idx_n;
    logic [23:0] shreg, shreg_n;
    logic        last_q, last_n;
    logic        dout_n;
    logic        bit_end;

    assign bit_end = (cnt == TBIT_M);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LATCH;
            cnt      <= 16'd0;
            idx      <= 5'd0;
            shreg    <= 24'd0;
            last_q   <= 1'b0;
            led_dout <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            last_q   <= last_n;
            led_dout <= dout_n;
        end
    end

    // led_dout is registered, so dout_n is the line level for the cycle whose
    // counter value is cnt_n. Every bit starts high because T0H > 0, which
    // also makes the first high cycle appear right after the accepting edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        last_n    = last_q;
        dout_n    = 1'b0;
        pix_ready = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                pix_ready = 1'b1;
                cnt_n     = 16'd0;
                if (pix_valid) begin
                    state_n = SEND;
                    idx_n   = 5'd23;
                    shreg_n = pix_data;
                    last_n  = pix_last;
                    dout_n  = 1'b1;
                end
            end

            SEND: begin
                // Only the final cycle of a non-last pixel may accept the
                // next one, giving gap-free back-to-back pixels.
                pix_ready = bit_end && (idx == 5'd0) && !last_q;
                if (!bit_end) begin
                    cnt_n  = cnt + 16'd1;
                    dout_n = shreg[23] ? ((cnt + 16'd1) < T1H_W)
                                       : ((cnt + 16'd1) < T0H_W);
                end else if (idx != 5'd0) begin
                    cnt_n   = 16'd0;
                    idx_n   = idx - 5'd1;
                    shreg_n = {shreg[22:0], 1'b0};
                    dout_n  = 1'b1;
                end else if (last_q) begin
                    state_n = LATCH;
                    cnt_n   = 16'd0;
                end else if (pix_valid) begin
                    cnt_n   = 16'd0;
                    idx_n   = 5'd23;
                    shreg_n = pix_data;
                    last_n  = pix_last;
                    dout_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = 16'd0;
                end
            end

            LATCH: begin
                if (cnt == RST_M) begin
                    state_n = IDLE;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            default: begin
                state_n = LATCH;
                cnt_n   = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver
// Directed bench for ws2812_driver with default timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// A sample index n after an accepting edge corresponds to bit n/62,
// position n%62 within that bit.

module tb_ws2812_driver;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int TBIT = 62;
    localparam int RC   = 15000;
    localparam int PIX  = 24 * TBIT;   // 1488

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] pix_data = 24'd0;
    logic        pix_last = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        led_dout;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ws2812_driver #(
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_data(pix_data), .pix_last(pix_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .led_dout(led_dout), .busy(busy)
    );

    function automatic logic exp_dout(input logic [23:0] d, input int n);
        int b;
        int c;
        b = n / TBIT;
        c = n % TBIT;
        if (b > 23) return 1'b0;
        return d[23 - b] ? (c < T1H) : (c < T0H);
    endfunction

    // Walks samples 0..cnt-1 of a pixel, stopping at sample cnt-1 without
    // advancing. Counts deviating samples and high samples.
    task automatic run_wave(input logic [23:0] d, input int cnt, input bit noise,
                            output int bad, output int hi);
        bad = 0;
        hi  = 0;
        for (int n = 0; n < cnt; n++) begin
            if (led_dout !== exp_dout(d, n) || busy !== 1'b1) bad++;
            if (n < PIX - 1 && pix_ready !== 1'b0) bad++;
            if (led_dout === 1'b1) hi++;
            if (n < cnt - 1) begin
                if (noise) begin
                    pix_valid = 1'($urandom_range(0, 1));
                    pix_data  = 24'($urandom);
                    pix_last  = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end
        if (noise) pix_valid = 1'b0;
    endtask

    // Walks RC samples of a latch period and lands on the first idle sample.
    task automatic run_latch(input bit noise, output int bad);
        bad = 0;
        for (int i = 0; i < RC; i++) begin
            if (led_dout !== 1'b0 || pix_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (noise) begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_data  = 24'($urandom);
                pix_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic offer(input logic [23:0] d, input logic last, input string name);
        vectors++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, pix_ready);
        end
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int bad;
        repeat (3) @(negedge clk);
        vectors++;
        if (led_dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", led_dout); end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        vectors++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
        reset_n = 1'b1;
        run_latch(1'b0, bad);
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL rst_latch: bad samples %0d want 0", bad); end
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b0 || led_dout !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: ready %b busy %b dout %b want 1 0 0", pix_ready, busy, led_dout);
        end
    endtask

    task automatic test_single_last;
        int bad, hi;
        offer(24'hFF0000, 1'b1, "single");
        pix_valid = 1'b0;
        run_wave(24'hFF0000, PIX, 1'b0, bad, hi);
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL single_wave: bad samples %0d want 0", bad); end
        vectors++;
        if (hi !== 640) begin errors++; $display("FAIL single_high: got %0d want 640", hi); end
        vectors++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL single_ready_last: got %b want 0", pix_ready); end
        @(negedge clk);
        run_latch(1'b1, bad);
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL single_latch: bad samples %0d want 0", bad); end
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: ready %b busy %b want 1 0", pix_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        int bad, hi;
        offer(24'h000001, 1'b0, "b2b");
        pix_data = 24'h800000;
        pix_last = 1'b1;
        run_wave(24'h000001, PIX, 1'b0, bad, hi);
        vectors++;
        if (bad !== 0 || hi !== 500) begin
            errors++;
            $display("FAIL b2b_wave1: bad %0d high %0d want 0 500", bad, hi);
        end
        vectors++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_1487: got %b want 1", pix_ready); end
        @(negedge clk);
        pix_valid = 1'b0;
        run_wave(24'h800000, PIX, 1'b0, bad, hi);
        vectors++;
        if (bad !== 0 || hi !== 500) begin
            errors++;
            $display("FAIL b2b_wave2: bad %0d high %0d want 0 500", bad, hi);
        end
        @(negedge clk);
        run_latch(1'b1, bad);
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_latch: bad samples %0d want 0", bad); end
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ready %b busy %b want 1 0", pix_ready, busy);
        end
    endtask

    task automatic test_no_latch;
        int bad, hi;
        offer(24'h0000FF, 1'b0, "nolatch");
        pix_valid = 1'b0;
        run_wave(24'h0000FF, PIX, 1'b0, bad, hi);
        vectors++;
        if (bad !== 0 || hi !== 640) begin
            errors++;
            $display("FAIL nolatch_wave: bad %0d high %0d want 0 640", bad, hi);
        end
        vectors++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL nolatch_ready_1487: got %b want 1", pix_ready); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || led_dout !== 1'b0 || pix_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL nolatch_idle: bad samples %0d want 0", bad); end
    endtask

    task automatic test_reset_mid;
        int bad, hi;
        offer(24'hFFFFFF, 1'b1, "midrst");
        pix_valid = 1'b0;
        run_wave(24'hFFFFFF, 10 * TBIT + 11, 1'b0, bad, hi);
        vectors++;
        if (bad !== 0 || led_dout !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: bad %0d dout %b want 0 1", bad, led_dout);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (led_dout !== 1'b0 || busy !== 1'b1 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: dout %b busy %b ready %b want 0 1 0", led_dout, busy, pix_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_latch(1'b0, bad);
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL midrst_latch: bad samples %0d want 0", bad); end
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: ready %b busy %b want 1 0", pix_ready, busy);
        end
    endtask

    task automatic test_ignore_valid;
        int bad, hi;
        offer(24'h00FF00, 1'b0, "ignore");
        run_wave(24'h00FF00, PIX, 1'b1, bad, hi);
        vectors++;
        if (bad !== 0 || hi !== 640) begin
            errors++;
            $display("FAIL ignore_wave: bad %0d high %0d want 0 640", bad, hi);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || led_dout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy %b dout %b want 0 0", busy, led_dout);
        end
    endtask

    initial begin
        test_reset();
        test_single_last();
        test_back_to_back();
        test_no_latch();
        test_reset_mid();
        test_ignore_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
